// File: rtl/snake_dir_queue.sv
// Snake game direction controller: per-player button synchroniser/debouncer,
// turn validation against the latest pending direction, and a turn FIFO drained one entry per tick.
module snake_dir_queue #(
    parameter int         N_PLAYERS       = 2,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         QUEUE_DEPTH     = 2,
    parameter logic [4:0] INIT_DIR        = 5'b10000,
    localparam int        CW              = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [N_PLAYERS-1:0]    btn_u,
    input  logic [N_PLAYERS-1:0]    btn_d,
    input  logic [N_PLAYERS-1:0]    btn_r,
    input  logic [N_PLAYERS-1:0]    btn_l,
    output logic [5*N_PLAYERS-1:0]  dir,
    output logic [CW*N_PLAYERS-1:0] q_count,
    output logic [N_PLAYERS-1:0]    overflow
);
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    localparam logic [4:0] DIR_R = 5'b10000;
    localparam logic [4:0] DIR_D = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b00100;
    localparam logic [4:0] DIR_U = 5'b00010;

    // Swaps R<->L and D<->U in the one-hot encoding.
    function automatic logic [4:0] opposite(input logic [4:0] d);
        return {d[2], d[1], d[4], d[3], 1'b0};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        // Button vectors are ordered {U, L, D, R}, matching selection priority.
        logic [3:0]     raw;
        logic [3:0]     sync1;
        logic [3:0]     sync2;
        logic [3:0]     level;
        logic [3:0]     level_q;
        logic [3:0]     press;
        logic [DCW-1:0] cnt [4];

        logic [4:0]     cand;
        logic           cand_valid;
        logic [4:0]     ref_dir;
        logic           accept;
        logic           do_push;
        logic           do_pop;
        logic           drop;

        logic [4:0]     mem [QUEUE_DEPTH];
        logic [PW-1:0]  head;
        logic [PW-1:0]  tail;
        logic [PW-1:0]  last;
        logic [CW-1:0]  count;
        logic [4:0]     dir_r;
        logic           ovf_r;

        assign raw = {btn_u[p], btn_l[p], btn_d[p], btn_r[p]};

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1   <= '0;
                sync2   <= '0;
                level   <= '0;
                level_q <= '0;
                press   <= '0;
                for (int b = 0; b < 4; b++) cnt[b] <= '0;
            end else begin
                sync1   <= raw;
                sync2   <= sync1;
                level_q <= level;
                press   <= level & ~level_q;
                for (int b = 0; b < 4; b++) begin
                    if (sync2[b] == level[b]) begin
                        cnt[b] <= '0;
                    end else if (cnt[b] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                        cnt[b]   <= '0;
                        level[b] <= ~level[b];
                    end else begin
                        cnt[b] <= cnt[b] + DCW'(1);
                    end
                end
            end
        end

        assign last = (tail == '0) ? PW'(QUEUE_DEPTH - 1) : tail - PW'(1);

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            cand       = '0;
            cand_valid = |press;
            if (press[3])      cand = DIR_U;
            else if (press[2]) cand = DIR_L;
            else if (press[1]) cand = DIR_D;
            else if (press[0]) cand = DIR_R;

            ref_dir = (count != '0) ? mem[last] : dir_r;
            accept  = cand_valid && (cand != ref_dir) && (cand != opposite(ref_dir));
            do_pop  = tick && (count != '0);
            // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
            do_push = accept && ((count < CW'(QUEUE_DEPTH)) || do_pop);
            drop    = accept && !do_push;
        end

        // NOTE: FIFO storage has no reset; occupancy gates every read, so stale
        // entries are never observed and the array can map to plain registers/RAM.
        always_ff @(posedge clk) begin
            if (do_push) mem[tail] <= cand;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                dir_r <= INIT_DIR;
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= drop;
                if (do_push) tail <= ptr_inc(tail);
                if (do_pop) begin
                    head  <= ptr_inc(head);
                    dir_r <= mem[head];
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

        assign dir[5*p +: 5]       = dir_r;
        assign q_count[CW*p +: CW] = count;
        assign overflow[p]         = ovf_r;
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue: table of button/tick steps with a
// scoreboard of expected player states, plus timed sequences for latency, tick/push overlap and reset.
module tb_snake_dir_queue;
    localparam int DEB   = 4;
    localparam int DEPTH = 2;

    localparam logic [4:0] R = 5'b10000;
    localparam logic [4:0] D = 5'b01000;
    localparam logic [4:0] L = 5'b00100;
    localparam logic [4:0] U = 5'b00010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] btn_u = '0;
    logic [1:0] btn_d = '0;
    logic [1:0] btn_r = '0;
    logic [1:0] btn_l = '0;
    logic [9:0] dir;
    logic [3:0] q_count;
    logic [1:0] overflow;

    snake_dir_queue #(
        .N_PLAYERS      (2),
        .DEBOUNCE_CYCLES(DEB),
        .QUEUE_DEPTH    (DEPTH),
        .INIT_DIR       (5'b10000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .btn_u   (btn_u),
        .btn_d   (btn_d),
        .btn_r   (btn_r),
        .btn_l   (btn_l),
        .dir     (dir),
        .q_count (q_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int         ovf_pulses [2] = '{0, 0};
    int         ovf_long   [2] = '{0, 0};
    logic [1:0] ovf_prev = '0;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (overflow[p] && !ovf_prev[p]) ovf_pulses[p]++;
            if (overflow[p] && ovf_prev[p])  ovf_long[p]++;
        end
        ovf_prev = overflow;
    end

    typedef struct {
        string      name;
        int         player;
        logic [3:0] btns;      // {U, L, D, R}
        bit         do_tick;
        logic [4:0] dir0;
        int         q0;
        logic [4:0] dir1;
        int         q1;
        int         ovf0;
        int         ovf1;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] dir0;
        int         q0;
        logic [4:0] dir1;
        int         q1;
        int         ovf0;
        int         ovf1;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic set_btns(input int p, input logic [3:0] b);
        btn_u[p] = b[3];
        btn_l[p] = b[2];
        btn_d[p] = b[1];
        btn_r[p] = b[0];
    endtask

    // Hold the buttons long enough to debounce, release, then let the release settle.
    task automatic press(input int p, input logic [3:0] b);
        @(negedge clk);
        set_btns(p, b);
        repeat (10) @(negedge clk);
        set_btns(p, 4'b0000);
        repeat (12) @(negedge clk);
    endtask

    // Same as press, but tick is high on exactly the edge that performs the push.
    task automatic press_with_tick(input int p, input logic [3:0] b);
        @(negedge clk);
        set_btns(p, b);
        repeat (3 + DEB) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        set_btns(p, 4'b0000);
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.name, "_dir0"}, 32'(dir[4:0]), 32'(e.dir0));
        check({e.name, "_q0"},   32'(q_count[1:0]), 32'(e.q0));
        check({e.name, "_dir1"}, 32'(dir[9:5]), 32'(e.dir1));
        check({e.name, "_q1"},   32'(q_count[3:2]), 32'(e.q1));
        check({e.name, "_ovf0"}, 32'(ovf_pulses[0]), 32'(e.ovf0));
        check({e.name, "_ovf1"}, 32'(ovf_pulses[1]), 32'(e.ovf1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                name            pl  btns     tk  dir0 q0 dir1 q1 o0 o1
        tbl.push_back('{"p0_rev_L",     0, 4'b0100, 0, R, 0, R, 0, 0, 0});
        tbl.push_back('{"p0_dup_R",     0, 4'b0001, 0, R, 0, R, 0, 0, 0});
        tbl.push_back('{"p0_D",         0, 4'b0010, 0, R, 1, R, 0, 0, 0});
        tbl.push_back('{"p0_U_vs_tail", 0, 4'b1000, 0, R, 1, R, 0, 0, 0});
        tbl.push_back('{"p0_tick",      0, 4'b0000, 1, D, 0, R, 0, 0, 0});
        tbl.push_back('{"p1_U",         1, 4'b1000, 0, D, 0, R, 1, 0, 0});
        tbl.push_back('{"p1_L",         1, 4'b0100, 0, D, 0, R, 2, 0, 0});
        tbl.push_back('{"p1_D_full",    1, 4'b0010, 0, D, 0, R, 2, 0, 1});
        tbl.push_back('{"tick_a",       1, 4'b0000, 1, D, 0, U, 1, 0, 1});
        tbl.push_back('{"tick_b",       1, 4'b0000, 1, D, 0, L, 0, 0, 1});
        tbl.push_back('{"p1_UR_prio",   1, 4'b1001, 1, D, 0, U, 0, 0, 1});
        tbl.push_back('{"p0_LDR_prio",  0, 4'b0111, 1, L, 0, U, 0, 0, 1});
        tbl.push_back('{"p0_DR_prio",   0, 4'b0011, 1, D, 0, U, 0, 0, 1});
        tbl.push_back('{"p0_R",         0, 4'b0001, 0, D, 1, U, 0, 0, 1});
        tbl.push_back('{"p0_U",         0, 4'b1000, 0, D, 2, U, 0, 0, 1});
        tbl.push_back('{"p1_R_tick",    1, 4'b0001, 1, R, 1, R, 0, 0, 1});
        tbl.push_back('{"tick_c",       0, 4'b0000, 1, U, 0, R, 0, 0, 1});

        // Reset and idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_dir",  32'(dir), 32'({R, R}));
        check("idle_q",    32'(q_count), 32'd0);
        check("idle_ovf",  32'(overflow), 32'd0);

        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].name, tbl[i].dir0, tbl[i].q0, tbl[i].dir1,
                           tbl[i].q1, tbl[i].ovf0, tbl[i].ovf1});
            if (tbl[i].btns != 4'b0000) press(tbl[i].player, tbl[i].btns);
            if (tbl[i].do_tick) pulse_tick();
            compare_next();
        end

        // Short glitches on P0 left (P0 is U, so a real L would be queued).
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            btn_l[0] = 1'b1;
            repeat (2) @(negedge clk);
            btn_l[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("glitch_q0",   32'(q_count[1:0]), 32'd0);
        check("glitch_dir0", 32'(dir[4:0]), 32'(U));

        // Press latency: push lands exactly 3+DEB edges after the first sampling edge.
        @(negedge clk);
        btn_r[0] = 1'b1;
        repeat (3 + DEB) @(negedge clk);
        check("latency_q0_before", 32'(q_count[1:0]), 32'd0);
        @(negedge clk);
        check("latency_q0_at",     32'(q_count[1:0]), 32'd1);
        check("latency_dir0_hold", 32'(dir[4:0]), 32'(U));
        repeat (2) @(negedge clk);
        btn_r[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("latency_q0_stable", 32'(q_count[1:0]), 32'd1);
        pulse_tick();
        check("latency_dir0_commit", 32'(dir[4:0]), 32'(R));
        check("latency_q0_drained",  32'(q_count[1:0]), 32'd0);

        // Full FIFO, tick on the push edge: occupancy holds, head commits, new entry at tail.
        press(0, 4'b1000);
        press(0, 4'b0100);
        check("full_q0", 32'(q_count[1:0]), 32'd2);
        press_with_tick(0, 4'b0010);
        check("fulltick_q0",   32'(q_count[1:0]), 32'd2);
        check("fulltick_dir0", 32'(dir[4:0]), 32'(U));
        check("fulltick_ovf0", 32'(ovf_pulses[0]), 32'd0);
        pulse_tick();
        check("drain1_dir0", 32'(dir[4:0]), 32'(L));
        check("drain1_q0",   32'(q_count[1:0]), 32'd1);
        pulse_tick();
        check("drain2_dir0", 32'(dir[4:0]), 32'(D));
        check("drain2_q0",   32'(q_count[1:0]), 32'd0);

        // Empty FIFO, tick on the push edge: entry is queued, committed on the next tick.
        press_with_tick(0, 4'b0001);
        check("emptytick_q0",   32'(q_count[1:0]), 32'd1);
        check("emptytick_dir0", 32'(dir[4:0]), 32'(D));
        pulse_tick();
        check("emptytick_commit", 32'(dir[4:0]), 32'(R));
        check("emptytick_q0_end", 32'(q_count[1:0]), 32'd0);

        // Reset mid-queue, with P1 up held through reset.
        press(0, 4'b1000);
        press(1, 4'b1000);
        check("prerst_q", 32'(q_count), 32'({2'd1, 2'd1}));
        @(negedge clk);
        btn_u[1] = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_dir", 32'(dir), 32'({R, R}));
        check("rst_q",   32'(q_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3 + DEB) @(negedge clk);
        check("rst_rebounce_q1_before", 32'(q_count[3:2]), 32'd0);
        @(negedge clk);
        check("rst_rebounce_q1_at",     32'(q_count[3:2]), 32'd1);
        check("rst_rebounce_dir1",      32'(dir[9:5]), 32'(R));
        check("rst_rebounce_q0",        32'(q_count[1:0]), 32'd0);
        btn_u[1] = 1'b0;
        repeat (12) @(negedge clk);

        check("ovf_width0",  32'(ovf_long[0]), 32'd0);
        check("ovf_width1",  32'(ovf_long[1]), 32'd0);
        check("ovf_total1",  32'(ovf_pulses[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
